// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: guaranteed scanout read per pixel strobe, two write ports share the rest.
// Build option VGA_ARB_FIXED_PRIO_EN: port A always beats port B (no last_grant state kept).
module vga_fb_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ck_stb,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              wa_valid,
    output logic              wa_ready,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic scan_slot;
    logic write_slot;
    logic grant_a;
    logic grant_b;
    logic rd_p1;
    logic rd_p2;

    // Scanout owns the RAM on every displayed strobe; everything else is a write slot.
    always_comb begin
        scan_slot  = ck_stb && scan_req;
        write_slot = reset && !scan_slot;
    end

`ifdef VGA_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_a = write_slot && wa_valid;
        grant_b = write_slot && wb_valid && !wa_valid;
    end
`else
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t last_grant;
    grant_t next_grant;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= next_grant;
        end
    end

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        next_grant = last_grant;
        if (write_slot) begin
            if (wa_valid && wb_valid) begin
                grant_a = (last_grant == GRANT_B);
                grant_b = (last_grant == GRANT_A);
            end else begin
                grant_a = wa_valid;
                grant_b = wb_valid;
            end
        end
        if (grant_a) begin
            next_grant = GRANT_A;
        end else if (grant_b) begin
            next_grant = GRANT_B;
        end
    end
`endif

    assign wa_ready = grant_a;
    assign wb_ready = grant_b;

    // Stage p0 -> p1: registered RAM command; address/data hold when the slot is unused.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (scan_slot) begin
                mem_addr <= scan_addr;
            end else if (grant_a) begin
                mem_addr  <= wa_addr;
                mem_wdata <= wa_data;
                mem_we    <= 1'b1;
            end else if (grant_b) begin
                mem_addr  <= wb_addr;
                mem_wdata <= wb_data;
                mem_we    <= 1'b1;
            end
        end
    end

    // Stages p1 -> p2 -> output: read valid tracks the RAM latency, p2 lands rdata.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
        end else begin
            rd_p1      <= scan_slot;
            rd_p2      <= rd_p1;
            scan_valid <= rd_p2;
            if (rd_p2) begin
                scan_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural RAM and scoreboards for scan reads and writes.
module tb_vga_fb_arbiter;
    localparam int AW = 19;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ck_stb = 1'b0;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic [DW-1:0] scan_data;
    logic          scan_valid;
    logic          wa_valid = 1'b0;
    logic          wa_ready;
    logic [AW-1:0] wa_addr = '0;
    logic [DW-1:0] wa_data = '0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } scan_exp_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    scan_exp_t     scan_q[$];
    wr_exp_t       wr_q[$];
    logic [DW-1:0] ram[logic [AW-1:0]];
    logic [DW-1:0] shadow[logic [AW-1:0]];

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .ck_stb(ck_stb), .scan_req(scan_req),
        .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM preloaded with 0xABC at 0x00123, zero elsewhere.
    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return (a == 19'h00123) ? 12'hABC : 12'h000;
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        if (shadow.exists(a)) return shadow[a];
        return (a == 19'h00123) ? 12'hABC : 12'h000;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= ram_rd(mem_addr);
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        scan_exp_t se;
        wr_exp_t   we;
        chk("dual_ready", 32'(wa_ready & wb_ready), 0);
        if (scan_valid) begin
            chk("scan_pending", 32'(scan_q.size() > 0), 1);
            if (scan_q.size() > 0) begin
                se = scan_q.pop_front();
                chk("scan_data_sb", 32'(scan_data), 32'(se.data));
                chk("scan_latency", 32'(cyc - se.cyc), 3);
            end
        end
        if (mem_we) begin
            chk("write_pending", 32'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                we = wr_q.pop_front();
                chk("mem_addr_sb", 32'(mem_addr), 32'(we.addr));
                chk("mem_wdata_sb", 32'(mem_wdata), 32'(we.data));
                chk("write_latency", 32'(cyc - we.cyc), 1);
            end
        end
        if (wa_valid && wa_ready) begin
            wr_q.push_back('{cyc: cyc, addr: wa_addr, data: wa_data});
            shadow[wa_addr] = wa_data;
        end
        if (wb_valid && wb_ready) begin
            wr_q.push_back('{cyc: cyc, addr: wb_addr, data: wb_data});
            shadow[wb_addr] = wb_data;
        end
        if (reset && ck_stb && scan_req)
            scan_q.push_back('{cyc: cyc, data: shadow_rd(scan_addr)});
        if (!reset) begin
            scan_q.delete();
            wr_q.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic exp_last_b;
        logic exp_a;
        int   nwr;

        // Reset held with a requester and toggling strobe.
        reset = 1'b0; wa_valid = 1'b1; scan_req = 1'b1; scan_addr = 19'h00123;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            ck_stb = (i % 2 == 0);
            sample();
            chk("rst_wa_ready", 32'(wa_ready), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_scan_valid", 32'(scan_valid), 0);
            chk("rst_scan_data", 32'(scan_data), 0);
        end
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        exp_last_b = 1'b1;

        next_cycle();
        reset = 1'b1; wa_valid = 1'b0; ck_stb = 1'b0; scan_req = 1'b0;

        // Single scan read of the preloaded word.
        next_cycle();
        ck_stb = 1'b1; scan_req = 1'b1; scan_addr = 19'h00123;
        sample();
        next_cycle();
        ck_stb = 1'b0;
        sample();
        chk("scan_mem_addr", 32'(mem_addr), 32'h00123);
        chk("scan_mem_we", 32'(mem_we), 0);
        next_cycle();
        sample();
        chk("scan_valid_n2", 32'(scan_valid), 0);
        next_cycle();
        sample();
        chk("scan_valid_n3", 32'(scan_valid), 1);
        chk("scan_data_n3", 32'(scan_data), 32'hABC);
        next_cycle();
        sample();
        chk("scan_valid_n4", 32'(scan_valid), 0);
        chk("scan_data_hold", 32'(scan_data), 32'hABC);

        // Scan preempts port A during display.
        nwr = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            ck_stb = (i % 4 == 0); scan_req = 1'b1; scan_addr = 19'(32'h200 + i);
            wa_valid = 1'b1; wa_addr = 19'(32'h300 + i); wa_data = 12'(32'h100 + i);
            sample();
            chk("preempt_wa_ready", 32'(wa_ready), 32'(!ck_stb));
            if (wa_ready) nwr++;
        end
        chk("preempt_writes", 32'(nwr), 9);
        exp_last_b = 1'b0;

        next_cycle();
        wa_valid = 1'b0; ck_stb = 1'b0; scan_req = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();

        // Contention during blanking.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            ck_stb = (i % 4 == 0); scan_req = 1'b0;
            wa_valid = 1'b1; wa_addr = 19'(32'h400 + i); wa_data = 12'(32'hA00 + i);
            wb_valid = 1'b1; wb_addr = 19'(32'h500 + i); wb_data = 12'(32'hB00 + i);
`ifdef VGA_ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = exp_last_b;
`endif
            sample();
            chk("rr_wa_ready", 32'(wa_ready), 32'(exp_a));
            chk("rr_wb_ready", 32'(wb_ready), 32'(!exp_a));
            exp_last_b = !exp_a;
        end

        next_cycle();
        wa_valid = 1'b0; wb_valid = 1'b0; ck_stb = 1'b0;
        for (int i = 0; i < 2; i++) next_cycle();

        // B write followed by a scan read of the same address.
        wb_valid = 1'b1; wb_addr = 19'h00010; wb_data = 12'h5A5; scan_req = 1'b1;
        sample();
        chk("ord_wb_ready", 32'(wb_ready), 1);
        next_cycle();
        wb_valid = 1'b0; ck_stb = 1'b1; scan_addr = 19'h00010;
        sample();
        chk("ord_mem_we", 32'(mem_we), 1);
        chk("ord_mem_addr", 32'(mem_addr), 32'h00010);
        next_cycle();
        ck_stb = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("ord_scan_valid", 32'(scan_valid), 1);
        chk("ord_scan_data", 32'(scan_data), 32'h5A5);

        // Reset one cycle after a strobed read.
        next_cycle();
        next_cycle();
        ck_stb = 1'b1; scan_req = 1'b1; scan_addr = 19'h00123;
        next_cycle();
        ck_stb = 1'b0; reset = 1'b0; wa_valid = 1'b1;
        sample();
        chk("mid_rst_wa_ready", 32'(wa_ready), 0);
        next_cycle();
        reset = 1'b1; wa_valid = 1'b0; scan_req = 1'b0;
        sample();
        chk("mid_rst_mem_we", 32'(mem_we), 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            chk("mid_rst_scan_valid", 32'(scan_valid), 0);
            chk("mid_rst_scan_data", 32'(scan_data), 0);
        end

        for (int i = 0; i < 4; i++) next_cycle();
        chk("scan_q_drained", 32'(scan_q.size()), 0);
        chk("wr_q_drained", 32'(wr_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter for the VGA pipeline. It shares one synchronous 12-bit-per-pixel RAM between two parties:

- **Scanout**: fixed-priority, guaranteed one read per 25 MHz pixel strobe.
- **Two write requesters (A, B)**: valid/ready handshakes that use the remaining 100 MHz cycles.

It sits between the timing generator (which supplies `ck_stb`, `display_on` and the pixel address) and the colour output registers.

## Interface

Parameters:
- `ADDR_W`, default 19: framebuffer address width (640×480 = 307200 words).
- `DATA_W`, default 12: pixel width, {r[3:0], g[3:0], b[3:0]}.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: synchronous, active-low reset.
- `ck_stb` in 1: pixel strobe, high one cycle in every 4.
- `scan_req` in 1: scanout read wanted this pixel; this is `display_on`.
- `scan_addr` in `ADDR_W`: pixel address, sampled when `ck_stb` is high.
- `scan_data` out `DATA_W`: last pixel read; holds between updates.
- `scan_valid` out 1: one-cycle pulse when `scan_data` updates.
- `wa_valid`, `wa_ready` in/out 1: port A handshake.
- `wa_addr` in `ADDR_W`, `wa_data` in `DATA_W`: port A write.
- `wb_valid`, `wb_ready` in/out 1: port B handshake.
- `wb_addr` in `ADDR_W`, `wb_data` in `DATA_W`: port B write.
- `mem_addr` out `ADDR_W`, `mem_we` out 1, `mem_wdata` out `DATA_W`: registered RAM command.
- `mem_rdata` in `DATA_W`: RAM read data, valid one cycle after the command.

## Operation

Every cycle carries at most one RAM operation. The decision is made in cycle n; the registered command appears in cycle n+1.

**Scan slot.** When `ck_stb && scan_req` in cycle n:
- Issue a read: `mem_addr=scan_addr`, `mem_we=0`.
- `wa_ready = wb_ready = 0` in cycle n.

**Write slot.** Any other cycle (including `ck_stb=1` with `scan_req=0`) is a write slot:
- If only one port is valid, that port gets ready=1.
- If both are valid, arbitration is round-robin: the port not granted last wins.
- The `last_grant` register updates only on a completed transfer (valid && ready).
- ready may depend combinationally on either valid, `ck_stb` and `scan_req`. ready never asserts while reset is low.

**Write execution.** A transfer in cycle n produces, in cycle n+1:
- `mem_we=1` for exactly one cycle;
- `mem_addr` and `mem_wdata` taken from the winning port.

**Idle.** When no slot is used, `mem_we=0` and `mem_addr`/`mem_wdata` hold their previous values.

**Read pipeline.** A 2-stage valid shift register (`rd_p1`, `rd_p2`) tracks each scan read:
- `rd_p2` captures `mem_rdata` into `scan_data`.
- `scan_valid` pulses in the same cycle that `scan_data` updates.

**Ordering.**
- A write completed before a scan read to the same address is visible to that read.
- A write completed in the scan-decision cycle is impossible, because ready is low in that cycle.

**Reset values** (reset low at a clock edge): `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `scan_data=0`, `scan_valid=0`, `rd_p1=rd_p2=0`, `last_grant=B` (so A wins the first contention).

**Reset mid-operation.** In-flight reads are discarded: no `scan_valid` pulse follows reset, and a pending `mem_we` is cleared.

## Timing

- **Scan latency:** `ck_stb` in cycle n → `mem_addr` in n+1 → `mem_rdata` in n+2 → `scan_data`/`scan_valid` in n+3. This is fixed at 3 cycles and finishes before the next strobe (n+4).
- **Write latency:** handshake in cycle n → `mem_we` in n+1.
- **Write bandwidth:** up to 3 writes per pixel period during display; 1 per cycle during blanking (`scan_req=0`).
- **Starvation bound under contention:**
  - Round-robin: each port is guaranteed a grant within 2 write slots.
  - With fixed priority (see Configuration), B can starve indefinitely.
- **`ck_stb` spacing:** the block supports strobes closer than 4 cycles. Each scan read still completes in exactly 3 cycles, and overlapping reads pipeline correctly.

## Configuration

- `VGA_ARB_FIXED_PRIO_EN` defined: port A always wins when both A and B are valid. `last_grant` is not implemented.
- Undefined (default): round-robin as described above.
- Scan priority and all latencies are identical in both builds.

## Test plan

- **Reset:** hold `reset=0` for 5 cycles with `wa_valid=1` and `ck_stb` toggling → `wa_ready=0`, `mem_we=0`, `scan_valid=0`, `scan_data=0` throughout.
- **Scan read:** preload RAM[0x00123]=0xABC; `ck_stb=1`, `scan_req=1`, `scan_addr=0x00123` at cycle n → `mem_addr=0x00123` at n+1, `scan_valid=1` and `scan_data=0xABC` at n+3, and `scan_valid=0` at n+4.
- **Scan preempts writes:** `wa_valid=1` held continuously during display with `ck_stb` every 4 cycles → `wa_ready=0` exactly on strobe cycles and 1 otherwise; 3 writes per 4 cycles.
- **Round-robin:** `wa_valid=wb_valid=1` held through blanking, default build → grants A,B,A,B…; `mem_wdata` alternates `wa_data`/`wb_data`. With `VGA_ARB_FIXED_PRIO_EN` → A every cycle, `wb_ready` never 1.
- **Write-then-read ordering:** B writes 0x5A5 to 0x00010 in cycle n, then a scan read of 0x00010 is strobed at n+1 → `scan_data=0x5A5` at n+4.
- **Reset mid-read:** strobe a read at cycle n, drive `reset=0` at n+1 → no `scan_valid` pulse at n+3, and `scan_data=0`.
